// File: rtl/rb_read_dispatcher.sv
// rtl/rb_read_dispatcher.sv - credit-throttled round-robin read issue and tagged drain of a DRAM read buffer
module rb_read_dispatcher #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int ADDRW    = 28,
  parameter int BURST    = 4,
  parameter int CAP      = 384,
  parameter int TAGDEPTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*ADDRW-1:0] req_addr_i,
  output logic [NREQ-1:0]       req_grant_o,
  output logic                  cmd_valid_o,
  output logic [ADDRW-1:0]      cmd_addr_o,
  input  logic                  cmd_ready_i,
  input  logic [127:0]          rb_data_i,
  input  logic                  rb_empty_i,
  input  logic                  rb_single_error_i,
  input  logic                  rb_double_error_i,
  output logic                  rb_rd_o,
  output logic                  ret_valid_o,
  output logic [127:0]          ret_data_o,
  output logic [IDW-1:0]        ret_dest_o,
  output logic                  ret_last_o,
  input  logic                  ret_ready_i,
  input  logic                  clear_err_i,
  output logic [15:0]           se_count_o,
  output logic                  de_flag_o,
  output logic [IDW-1:0]        de_dest_o,
  output logic                  orphan_err_o
);

  localparam int OUTW = $clog2(CAP + BURST + 1);
  localparam int BW   = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int TAW  = $clog2(TAGDEPTH);

  logic [OUTW-1:0] out_q, out_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [TAW:0]    wr_q, rd_q;
  logic [IDW-1:0]  tag_mem [TAGDEPTH];
  logic [15:0]     se_q, se_d;
  logic            de_flag_q, de_flag_d;
  logic [IDW-1:0]  de_dest_q, de_dest_d;
  logic            orphan_q, orphan_d;

  logic            tag_empty;
  logic            can_issue;
  logic            any_req;
  logic            hs;
  logic [IDW-1:0]  winner;

  // Scan downward so the last hit is the first requester at or after rr_q.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(rr_q) + k) % NREQ]) begin
        winner  = IDW'((int'(rr_q) + k) % NREQ);
        any_req = 1'b1;
      end
    end
  end

  assign can_issue   = (int'(out_q) + BURST) <= CAP;
  assign cmd_valid_o = any_req & can_issue;
  assign cmd_addr_o  = req_addr_i[int'(winner)*ADDRW +: ADDRW];
  assign hs          = cmd_valid_o & cmd_ready_i;
  assign req_grant_o = hs ? (NREQ'(1) << winner) : '0;

  assign tag_empty   = (wr_q == rd_q);
  assign ret_valid_o = ~rb_empty_i & ~tag_empty;
  assign ret_data_o  = rb_data_i;
  assign ret_dest_o  = tag_empty ? '0 : tag_mem[rd_q[TAW-1:0]];
  assign ret_last_o  = ret_valid_o & (beat_q == BW'(BURST - 1));
  assign rb_rd_o     = ret_valid_o & ret_ready_i;

  always_comb begin
    out_d = out_q + (hs ? OUTW'(BURST) : '0) - (rb_rd_o ? OUTW'(1) : '0);
    rr_d  = rr_q;
    if (hs) rr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    beat_d = beat_q;
    if (rb_rd_o) beat_d = ret_last_o ? '0 : beat_q + 1'b1;
  end

  // A same-cycle error event overrides the clear.
  always_comb begin
    se_d      = se_q;
    de_flag_d = de_flag_q;
    de_dest_d = de_dest_q;
    orphan_d  = orphan_q;
    if (clear_err_i) begin
      se_d      = '0;
      de_flag_d = 1'b0;
      de_dest_d = '0;
      orphan_d  = 1'b0;
    end
    if (rb_rd_o && rb_single_error_i)
      se_d = clear_err_i ? 16'd1 : ((se_q == 16'hFFFF) ? se_q : se_q + 16'd1);
    if (rb_rd_o && rb_double_error_i) begin
      de_flag_d = 1'b1;
      if (!de_flag_q || clear_err_i) de_dest_d = ret_dest_o;
    end
    if (!rb_empty_i && tag_empty) orphan_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      rr_q      <= '0;
      beat_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      se_q      <= '0;
      de_flag_q <= 1'b0;
      de_dest_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      out_q     <= out_d;
      rr_q      <= rr_d;
      beat_q    <= beat_d;
      se_q      <= se_d;
      de_flag_q <= de_flag_d;
      de_dest_q <= de_dest_d;
      orphan_q  <= orphan_d;
      if (hs) wr_q <= wr_q + 1'b1;
      if (rb_rd_o && ret_last_o) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) tag_mem[wr_q[TAW-1:0]] <= winner;
  end

  assign se_count_o   = se_q;
  assign de_flag_o    = de_flag_q;
  assign de_dest_o    = de_dest_q;
  assign orphan_err_o = orphan_q;

endmodule

// File: tb/tb_rb_read_dispatcher.sv
// tb/tb_rb_read_dispatcher.sv - directed bench for rb_read_dispatcher
module tb_rb_read_dispatcher;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int ADDRW = 28;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ-1:0]       req_grant;
  logic                  cmd_valid;
  logic [ADDRW-1:0]      cmd_addr;
  logic                  cmd_ready;
  logic [127:0]          rb_data;
  logic                  rb_empty;
  logic                  rb_single_error;
  logic                  rb_double_error;
  logic                  rb_rd;
  logic                  ret_valid;
  logic [127:0]          ret_data;
  logic [IDW-1:0]        ret_dest;
  logic                  ret_last;
  logic                  ret_ready;
  logic                  clear_err;
  logic [15:0]           se_count;
  logic                  de_flag;
  logic [IDW-1:0]        de_dest;
  logic                  orphan_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rb_read_dispatcher dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_grant_o(req_grant),
    .cmd_valid_o(cmd_valid), .cmd_addr_o(cmd_addr), .cmd_ready_i(cmd_ready),
    .rb_data_i(rb_data), .rb_empty_i(rb_empty),
    .rb_single_error_i(rb_single_error), .rb_double_error_i(rb_double_error),
    .rb_rd_o(rb_rd), .ret_valid_o(ret_valid), .ret_data_o(ret_data),
    .ret_dest_o(ret_dest), .ret_last_o(ret_last), .ret_ready_i(ret_ready),
    .clear_err_i(clear_err), .se_count_o(se_count), .de_flag_o(de_flag),
    .de_dest_o(de_dest), .orphan_err_o(orphan_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    cmd_ready = 1'b0;
    rb_data = '0;
    rb_empty = 1'b1;
    rb_single_error = 1'b0;
    rb_double_error = 1'b0;
    ret_ready = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) req_addr[i*ADDRW +: ADDRW] = ADDRW'(28'h100 + i);
    @(negedge clk);
    do_reset();

    // reset state
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_grant", req_grant, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_rb_rd", rb_rd, 0);
    chk("rst_se", se_count, 0);
    chk("rst_de_flag", de_flag, 0);
    chk("rst_de_dest", de_dest, 0);
    chk("rst_orphan", orphan_err, 0);
    chk("rst_out", dut.out_q, 0);
    @(negedge clk);

    // 1: alternating grants until credits run out, then refill
    req_valid = 4'b0101;
    cmd_ready = 1'b1;
    for (int g = 0; g < 96; g++) begin
      #1;
      chk("t1_valid", cmd_valid, 1);
      chk("t1_grant", req_grant, (g % 2 == 0) ? 4'b0001 : 4'b0100);
      chk("t1_addr", cmd_addr, (g % 2 == 0) ? 28'h100 : 28'h102);
      @(negedge clk);
    end
    #1;
    chk("t1_full_valid", cmd_valid, 0);
    chk("t1_full_grant", req_grant, 0);
    chk("t1_full_out", dut.out_q, 384);
    rb_empty = 1'b0;
    ret_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      rb_data = 128'h1000 + b;
      #1;
      chk("t1_pop_valid", cmd_valid, 0);
      chk("t1_pop_rd", rb_rd, 1);
      chk("t1_pop_dest", ret_dest, 0);
      chk("t1_pop_last", ret_last, (b == 3) ? 1 : 0);
      @(negedge clk);
    end
    rb_empty = 1'b1;
    cmd_ready = 1'b0;
    #1;
    chk("t1_out380", dut.out_q, 380);
    chk("t1_revalid", cmd_valid, 1);
    chk("t1_rearb_addr", cmd_addr, 28'h100);
    chk("t1_nogrant", req_grant, 0);
    @(negedge clk);

    // 2: two bursts for IDs 1 and 3
    do_reset();
    req_valid = 4'b0010;
    cmd_ready = 1'b1;
    #1;
    chk("t2_grant1", req_grant, 4'b0010);
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    chk("t2_grant3", req_grant, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    cmd_ready = 1'b0;
    rb_empty = 1'b0;
    ret_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      rb_data = 128'h2000 + w;
      #1;
      chk("t2_ret_valid", ret_valid, 1);
      chk("t2_rd", rb_rd, 1);
      chk("t2_dest", ret_dest, (w < 4) ? 1 : 3);
      chk("t2_last", ret_last, (w % 4 == 3) ? 1 : 0);
      chk("t2_data", ret_data, 128'h2000 + w);
      @(negedge clk);
    end
    rb_empty = 1'b1;
    #1;
    chk("t2_tag_empty", dut.tag_empty, 1);
    chk("t2_out", dut.out_q, 0);
    chk("t2_ret_valid_end", ret_valid, 0);
    @(negedge clk);

    // 3: back-pressure from the return sink
    do_reset();
    req_valid = 4'b0001;
    cmd_ready = 1'b1;
    #1;
    chk("t3_grant", req_grant, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    cmd_ready = 1'b0;
    rb_empty = 1'b0;
    ret_ready = 1'b1;
    rb_data = 128'h3000;
    #1;
    chk("t3_first_rd", rb_rd, 1);
    @(negedge clk);
    rb_data = 128'h3001;
    ret_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t3_hold_rd", rb_rd, 0);
      chk("t3_hold_data", ret_data, 128'h3001);
      chk("t3_hold_dest", ret_dest, 0);
      chk("t3_hold_beat", dut.beat_q, 1);
      @(negedge clk);
    end
    ret_ready = 1'b1;
    #1;
    chk("t3_resume_rd", rb_rd, 1);
    chk("t3_resume_last", ret_last, 0);
    @(negedge clk);
    rb_data = 128'h3002;
    #1;
    chk("t3_beat2_last", ret_last, 0);
    @(negedge clk);
    rb_data = 128'h3003;
    #1;
    chk("t3_beat3_last", ret_last, 1);
    @(negedge clk);
    rb_empty = 1'b1;
    #1;
    chk("t3_out", dut.out_q, 0);
    @(negedge clk);

    // 4: ECC status accumulation and clear
    do_reset();
    cmd_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("t4_grant_a", req_grant, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    chk("t4_grant_b", req_grant, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("t4_grant_c", req_grant, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    cmd_ready = 1'b0;
    rb_empty = 1'b0;
    ret_ready = 1'b1;
    for (int w = 0; w < 12; w++) begin
      rb_data = 128'h4000 + w;
      rb_single_error = (w < 3) || (w == 9);
      rb_double_error = (w == 4) || (w == 8);
      clear_err = (w == 9);
      #1;
      chk("t4_dest", ret_dest, (w >= 4 && w < 8) ? 2 : 0);
      if (w == 3) chk("t4_se3", se_count, 3);
      if (w == 5) chk("t4_de_flag", de_flag, 1);
      if (w == 5) chk("t4_de_dest", de_dest, 2);
      if (w == 9) chk("t4_de_dest_kept", de_dest, 2);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("t4_se_after_clear", se_count, 1);
    chk("t4_de_flag_cleared", de_flag, 0);
    chk("t4_de_dest_cleared", de_dest, 0);
    @(negedge clk);

    // 5: orphan data in the buffer
    do_reset();
    rb_empty = 1'b0;
    ret_ready = 1'b1;
    #1;
    chk("t5_rd", rb_rd, 0);
    chk("t5_ret_valid", ret_valid, 0);
    chk("t5_orphan_pre", orphan_err, 0);
    @(negedge clk);
    #1;
    chk("t5_orphan_set", orphan_err, 1);
    rb_empty = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_orphan_sticky", orphan_err, 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    #1;
    chk("t5_orphan_clear", orphan_err, 0);
    rb_empty = 1'b0;
    @(negedge clk);
    rb_empty = 1'b1;
    #1;
    chk("t5_orphan_again", orphan_err, 1);
    do_reset();
    #1;
    chk("t5_orphan_reset", orphan_err, 0);
    @(negedge clk);

    // 6: asynchronous reset mid-burst
    do_reset();
    req_valid = 4'b1111;
    cmd_ready = 1'b1;
    for (int g = 0; g < 10; g++) begin
      #1;
      chk("t6_grant", req_grant, 4'b0001 << (g % 4));
      @(negedge clk);
    end
    req_valid = '0;
    cmd_ready = 1'b0;
    rb_empty = 1'b0;
    ret_ready = 1'b1;
    rb_data = 128'h6000;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("t6_dest", ret_dest, 0);
      @(negedge clk);
    end
    #1;
    chk("t6_beat2", dut.beat_q, 2);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("t6_ret_valid", ret_valid, 0);
    chk("t6_rd", rb_rd, 0);
    chk("t6_last", ret_last, 0);
    chk("t6_dest_zero", ret_dest, 0);
    chk("t6_cmd_valid", cmd_valid, 0);
    chk("t6_out", dut.out_q, 0);
    chk("t6_beat", dut.beat_q, 0);
    chk("t6_tag_empty", dut.tag_empty, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1010;
    cmd_ready = 1'b1;
    #1;
    chk("t6_first_grant", req_grant, 4'b0010);
    chk("t6_first_addr", cmd_addr, 28'h101);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
